// File: rtl/sparc_mul_cntl_pkg.sv
// sparc_mul_cntl_pkg: shared latency default, tracker entry layout and grant encoding.
package sparc_mul_cntl_pkg;
    localparam int MUL_LATENCY = 5;
    localparam logic GNT_EXU = 1'b0;
    localparam logic GNT_SPU = 1'b1;
    typedef struct packed {
        logic vld;
        logic spu;
        logic acc;
        logic acc_lo;
    } trk_t;
endpackage

// File: rtl/sparc_mul_cntl_mul_pipe_trk.sv
// mul_pipe_trk: LATENCY-deep shift register following each issued multiply to its landing stage.
module mul_pipe_trk
    import sparc_mul_cntl_pkg::*;
#(
    parameter int LATENCY = MUL_LATENCY
) (
    input  logic rclk,
    input  logic rst_l,
    input  trk_t ent,
    output trk_t land
);
    trk_t [LATENCY-1:0] stg;

    always_ff @(posedge rclk or negedge rst_l)
        if (!rst_l) stg <= '0;
        else        stg <= {stg[LATENCY-2:0], ent};

    assign land = stg[LATENCY-1];
endmodule

// File: rtl/sparc_mul_cntl.sv
// sparc_mul_cntl: EXU/SPU multiply arbitration, datapath operand controls and ACCUM sequencing.
module sparc_mul_cntl
    import sparc_mul_cntl_pkg::*;
#(
    parameter int LATENCY = MUL_LATENCY
) (
    input  logic rclk,
    input  logic rst_l,
    input  logic ecl_mul_req_vld,
    input  logic spu_mul_req_vld,
    input  logic spu_mul_acc,
    input  logic spu_mul_acc_lo,
    input  logic spu_mul_byp,
    input  logic spu_mul_x2,
    input  logic spu_mul_areg_rst,
    input  logic spu_mul_areg_shf,
    output logic valid,
    output logic spick,
    output logic x2,
    output logic byp_sel,
    output logic byp_imm,
    output logic acc_imm,
    output logic acc_actc2,
    output logic acc_actc3,
    output logic acc_actc5,
    output logic acc_reg_enb,
    output logic acc_reg_rst,
    output logic acc_reg_shf,
    output logic mul_ecl_ack,
    output logic mul_spu_ack,
    output logic mul_exu_data_vld,
    output logic mul_spu_data_vld
);
    logic prio, pend, land_spu, shf_req;
    trk_t ent, land;

    // prio names the requester that wins the next contention; EXU first out of reset
    assign spick = rst_l & spu_mul_req_vld & (~ecl_mul_req_vld | (prio == GNT_SPU));
    assign valid = rst_l & (ecl_mul_req_vld | spu_mul_req_vld);
    assign mul_spu_ack = spick;
    assign mul_ecl_ack = rst_l & ecl_mul_req_vld & ~spick;

    assign land_spu = land.vld & land.spu;
    assign x2 = spick & spu_mul_x2;
    assign byp_sel = spick & spu_mul_byp;
    assign byp_imm = byp_sel & land_spu;
    assign acc_actc3 = spick & spu_mul_acc;
    assign acc_actc2 = spick & spu_mul_acc_lo;
    assign acc_imm = (acc_actc3 | acc_actc2) & land_spu & (land.acc | land.acc_lo);
    assign acc_actc5 = acc_actc2 & acc_imm;

    // a shift colliding with an ACCUM write is deferred to the next free cycle; clear wins over both
    assign shf_req = spu_mul_areg_shf | pend;
    assign acc_reg_enb = land_spu;
    assign acc_reg_rst = rst_l & spu_mul_areg_rst;
    assign acc_reg_shf = rst_l & shf_req & ~spu_mul_areg_rst & ~land_spu;
    assign mul_exu_data_vld = land.vld & ~land.spu;
    assign mul_spu_data_vld = land_spu;

    assign ent = '{vld: valid, spu: spick, acc: acc_actc3, acc_lo: acc_actc2};

    mul_pipe_trk #(.LATENCY(LATENCY)) u_trk (
        .rclk (rclk),
        .rst_l(rst_l),
        .ent  (ent),
        .land (land)
    );

    always_ff @(posedge rclk or negedge rst_l)
        if (!rst_l) begin
            prio <= GNT_EXU;
            pend <= 1'b0;
        end else begin
            if (valid) prio <= spick ? GNT_EXU : GNT_SPU;
            pend <= ~spu_mul_areg_rst & shf_req & land_spu;
        end
endmodule
